// File: rtl/rv_decode_pkg.sv
// Shared opcode constants, op class enum and decoded entry payload.
package rv_decode_pkg;

  localparam int unsigned XLEN_MAX = 64;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // NONE is zero so a cleared entry reads as "no class".
  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_LOAD   = 4'd1,
    CLS_STORE  = 4'd2,
    CLS_BRANCH = 4'd3,
    CLS_JAL    = 4'd4,
    CLS_JALR   = 4'd5,
    CLS_OP     = 4'd6,
    CLS_OP_IMM = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9,
    CLS_SYSTEM = 4'd10
  } op_class_e;

  // pc/imm are sized for the widest XLEN; narrower builds use the low bits.
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    op_class_e           cls;
    logic [XLEN_MAX-1:0] imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                rs1_valid;
    logic                rs2_valid;
    logic                rd_valid;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                illegal;
  } decoded_t;

endpackage

// File: rtl/rv_decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface rv_decode_if #(parameter int unsigned XLEN = 32);
  import rv_decode_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instruction;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  op_class_e       out_class;
  logic [XLEN-1:0] out_immediate;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rs1_valid;
  logic            out_rs2_valid;
  logic            out_rd_valid;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic            out_illegal;

  // Surrounding pipeline: drives fetch data and downstream ready.
  modport master (
    output in_valid, in_instruction, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_class, out_immediate,
           out_rs1, out_rs2, out_rd, out_rs1_valid, out_rs2_valid,
           out_rd_valid, out_funct3, out_funct7, out_illegal
  );

  // Decode stage.
  modport slave (
    input  in_valid, in_instruction, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_class, out_immediate,
           out_rs1, out_rs2, out_rd, out_rs1_valid, out_rs2_valid,
           out_rd_valid, out_funct3, out_funct7, out_illegal
  );

endinterface

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I/RV64I decode of one instruction word.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_pc,
  output decoded_t        o_dec_c
);

  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic                w_rv64;
  logic [XLEN_MAX-1:0] w_imm_i;
  logic [XLEN_MAX-1:0] w_imm_s;
  logic [XLEN_MAX-1:0] w_imm_b;
  logic [XLEN_MAX-1:0] w_imm_u;
  logic [XLEN_MAX-1:0] w_imm_j;
  op_class_e           w_cls;
  logic [XLEN_MAX-1:0] w_imm;
  logic                w_ill;

  assign w_opcode = i_instruction[6:0];
  assign w_funct3 = i_instruction[14:12];
  assign w_funct7 = i_instruction[31:25];
  assign w_rv64   = (XLEN == 64);

  // Immediates sign-extended from bit 31 to the widest width.
  assign w_imm_i = {{52{i_instruction[31]}}, i_instruction[31:20]};
  assign w_imm_s = {{52{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
  assign w_imm_b = {{52{i_instruction[31]}}, i_instruction[7], i_instruction[30:25],
                    i_instruction[11:8], 1'b0};
  assign w_imm_u = {{32{i_instruction[31]}}, i_instruction[31:12], 12'b0};
  assign w_imm_j = {{44{i_instruction[31]}}, i_instruction[19:12], i_instruction[20],
                    i_instruction[30:21], 1'b0};

  // Class, immediate selection and illegal-encoding detection.
  always_comb begin
    w_cls = CLS_NONE;
    w_imm = '0;
    w_ill = 1'b0;
    case (w_opcode)
      OPC_LOAD: begin
        w_cls = CLS_LOAD;
        w_imm = w_imm_i;
        w_ill = (w_funct3 == 3'd7) || (!w_rv64 && ((w_funct3 == 3'd3) || (w_funct3 == 3'd6)));
      end
      OPC_STORE: begin
        w_cls = CLS_STORE;
        w_imm = w_imm_s;
        w_ill = w_rv64 ? (w_funct3 >= 3'd4) : (w_funct3 >= 3'd3);
      end
      OPC_BRANCH: begin
        w_cls = CLS_BRANCH;
        w_imm = w_imm_b;
        w_ill = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
      end
      OPC_JAL: begin
        w_cls = CLS_JAL;
        w_imm = w_imm_j;
      end
      OPC_JALR: begin
        w_cls = CLS_JALR;
        w_imm = w_imm_i;
        w_ill = (w_funct3 != 3'd0);
      end
      OPC_OP: begin
        w_cls = CLS_OP;
        w_ill = !((w_funct7 == 7'h00) ||
                  ((w_funct7 == 7'h20) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5))));
      end
      OPC_OP_IMM: begin
        w_cls = CLS_OP_IMM;
        w_imm = w_imm_i;
      end
      OPC_LUI: begin
        w_cls = CLS_LUI;
        w_imm = w_imm_u;
      end
      OPC_AUIPC: begin
        w_cls = CLS_AUIPC;
        w_imm = w_imm_u;
      end
      OPC_SYSTEM: begin
        w_cls = CLS_SYSTEM;
        w_imm = w_imm_i;
      end
      default: w_ill = 1'b1;
    endcase
    if (i_instruction[1:0] != 2'b11) w_ill = 1'b1;
  end

  // Assemble the entry; illegal entries carry no class, immediate or field valids.
  always_comb begin
    o_dec_c         = '0;
    o_dec_c.pc      = XLEN_MAX'(i_pc);
    o_dec_c.rs1     = i_instruction[19:15];
    o_dec_c.rs2     = i_instruction[24:20];
    o_dec_c.rd      = i_instruction[11:7];
    o_dec_c.funct3  = w_funct3;
    o_dec_c.funct7  = w_funct7;
    o_dec_c.illegal = w_ill;
    if (!w_ill) begin
      o_dec_c.cls       = w_cls;
      o_dec_c.imm       = w_imm;
      o_dec_c.rs1_valid = w_cls inside {CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JALR,
                                        CLS_OP, CLS_OP_IMM, CLS_SYSTEM};
      o_dec_c.rs2_valid = w_cls inside {CLS_STORE, CLS_BRANCH, CLS_OP};
      o_dec_c.rd_valid  = (i_instruction[11:7] != 5'd0) &&
                          (w_cls inside {CLS_LOAD, CLS_JAL, CLS_JALR, CLS_OP, CLS_OP_IMM,
                                         CLS_LUI, CLS_AUIPC, CLS_SYSTEM});
      if (w_cls == CLS_OP_IMM) begin
        if ((w_funct3 == 3'd1) || (w_funct3 == 3'd5)) begin
          // On RV64 bit 25 belongs to shamt, not funct7.
          o_dec_c.funct7 = w_rv64 ? {i_instruction[31:26], 1'b0} : w_funct7;
        end else begin
          o_dec_c.funct7 = 7'd0;
        end
      end
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage: combinational decode feeding a two-entry skid buffer.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  rv_decode_if.slave bus
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b10;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  decoded_t   r_main;
  decoded_t   r_skid;
  decoded_t   w_main_nxt;
  decoded_t   w_skid_nxt;
  decoded_t   w_dec;
  logic       r_out_valid;
  logic       r_in_ready;
  logic       w_accept;
  logic       w_drain;
  logic       w_unused_hi;

  rv_decode_comb #(.XLEN(XLEN)) u_comb (
    .i_instruction (bus.in_instruction),
    .i_pc          (bus.in_pc),
    .o_dec_c       (w_dec)
  );

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_drain  = r_out_valid & bus.out_ready;

  // Next-state and entry movement; main entry always feeds the outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_main_nxt  = w_dec;
        end
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          w_main_nxt = w_dec;
        end else if (w_accept) begin
          w_state_nxt = ST_TWO;
          w_skid_nxt  = w_dec;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_drain) begin
          w_state_nxt = ST_ONE;
          w_main_nxt  = r_skid;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end
  end

  // State, entries and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_TWO);
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_pc        = r_main.pc[XLEN-1:0];
  assign bus.out_class     = r_main.cls;
  assign bus.out_immediate = r_main.imm[XLEN-1:0];
  assign bus.out_rs1       = r_main.rs1;
  assign bus.out_rs2       = r_main.rs2;
  assign bus.out_rd        = r_main.rd;
  assign bus.out_rs1_valid = r_main.rs1_valid;
  assign bus.out_rs2_valid = r_main.rs2_valid;
  assign bus.out_rd_valid  = r_main.rd_valid;
  assign bus.out_funct3    = r_main.funct3;
  assign bus.out_funct7    = r_main.funct7;
  assign bus.out_illegal   = r_main.illegal;

  // pc/imm bits above XLEN are dropped on purpose.
  assign w_unused_hi = ^{r_main.pc, r_main.imm};

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Registered, parametrised RV32I/RV64I instruction decode stage sitting between fetch and register-read/execute. Decodes one 32-bit instruction per cycle into operand fields, sign-extended XLEN-wide immediates and an illegal-instruction flag. Data is held behind a valid/ready handshake with a two-entry skid buffer, so `in_ready` is registered. The stage also supports a pipeline flush.

## Interface
- `XLEN`, 32, datapath width; legal values 32 or 64. Sizes the immediate and PC, and selects RV64 load/store/shift legality.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all buffered entries and any same-cycle input.
- `in_valid`  in  1  fetch offers an instruction.
- `in_ready`  out  XLEN-independent 1  registered; the stage can accept.
- `in_instruction`  in  32  raw instruction word.
- `in_pc`  in  XLEN  address of the instruction.
- `out_valid`  out  1  a decoded entry is presented.
- `out_ready`  in  1  downstream accepts.
- `out_pc`  out  XLEN  PC of the presented entry.
- `out_class`  out  4  `op_class_e`: LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC, SYSTEM, NONE.
- `out_immediate`  out  XLEN  sign-extended immediate; 0 when the class has no immediate.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices.
- `out_rs1_valid`, `out_rs2_valid`, `out_rd_valid`  out  1 each  field is used. `out_rd_valid` is 0 when rd = x0.
- `out_funct3`  out  3  funct3.
- `out_funct7`  out  7  funct7; forced 0 for non-shift OP_IMM.
- `out_illegal`  out  1  entry is an illegal encoding.

## Operation
- **Decode.** Decode is combinational on the input side. Decoded results are written into the buffer, so outputs are fully registered.
- **Immediates.** All immediates sign-extend from instruction bit 31 to XLEN:
  - I: `[31:20]`
  - S: `{[31:25],[11:7]}`
  - B: `{[31],[7],[30:25],[11:8],0}`
  - U: `{[31:12],12'b0}`
  - J: `{[31],[19:12],[20],[30:21],0}`
- **Field validity.**
  - rs1 is valid for LOAD, STORE, BRANCH, JALR, OP, OP_IMM and SYSTEM.
  - rs2 is valid for STORE, BRANCH and OP.
  - rd is valid for LOAD, JAL, JALR, OP, OP_IMM, LUI, AUIPC and SYSTEM, and only when `[11:7]` ≠ 0.
- **Shift immediates (funct3 1/5).**
  - XLEN=32: funct7 = `[31:25]`.
  - XLEN=64: funct7 = `{[31:26],1'b0}`; bit 25 is shamt[5].
- **`out_illegal` = 1** when any of the following holds:
  - `[1:0]` ≠ 2'b11;
  - the opcode is not one of the 10 classes;
  - JALR with funct3 ≠ 0;
  - BRANCH with funct3 ∈ {2,3};
  - LOAD with funct3 ∈ {7}, or additionally {3,6} when XLEN=32;
  - STORE with funct3 ≥ 4, or ≥ 3 when XLEN=32;
  - OP with funct7 ∉ {0x00,0x20}, or 0x20 with funct3 ∉ {0,5}.
- **Illegal entries.** An illegal entry is still delivered with `out_valid` = 1. Its class is NONE and all `*_valid` field flags are 0, so the trap is raised downstream.
- **Buffer FSM.** State is `EMPTY`, `ONE` or `TWO`. The main entry drives the outputs; the skid entry holds overflow.
  - Accept = `in_valid & in_ready`. Drain = `out_valid & out_ready`.
  - EMPTY + accept → ONE.
  - ONE: accept only → TWO; drain only → EMPTY; both → ONE, with the main entry replaced.
  - TWO + drain → ONE, with the skid entry moved to main. No accept is possible in TWO.
- **`in_ready`.** Registered; equals (next state ≠ TWO).
- **Ordering.** FIFO order is preserved and no entry is lost or duplicated.
- **Flush.**
  - Next state is EMPTY, `out_valid` = 0 and `in_ready` = 1.
  - Any same-cycle accept is dropped.
  - Flush has priority over everything except `rst`.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is on the outputs after edge N, when starting from EMPTY or from ONE with a simultaneous drain.
- Throughput is 1 per cycle with `out_ready` held at 1.
- Output data is stable while `out_valid & !out_ready`.
- Reset values (next edge with `rst` = 1):
  - state EMPTY, `out_valid` 0, `in_ready` 1;
  - all data outputs 0 and `out_class` NONE.
- Reset mid-operation discards both entries identically to flush.

## Structure
- Package `rv_decode_pkg` holds:
  - opcode localparams;
  - `op_class_e`;
  - the `decoded_t` struct (pc, class, imm, register fields and their valids, funct fields, illegal).
- Sub-module `rv_decode_comb` (parameter XLEN) is pure combinational decode of instruction + pc into `decoded_t`.
- `rv_decode_stage` instantiates `rv_decode_comb` once and contains only the skid buffer and FSM.

## Test plan
- **Sign-extended I-immediate.** XLEN=32, `0xFFF00093` (addi x1,x0,-1), `out_ready` = 1 → one cycle later: class OP_IMM, imm `0xFFFFFFFF`, rd 1, rd_valid 1, rs1 0, illegal 0.
- **Branch immediate.** `0xFE000EE3` (beq x0,x0,-4) → imm `0xFFFFFFFC`, rs1_valid and rs2_valid 1, rd_valid 0. XLEN=64, `0x800000B7` (lui x1,0x80000) → imm `0xFFFFFFFF80000000`.
- **Backpressure.** Hold `out_ready` = 0 and offer A, B, C back-to-back → A and B accepted, `in_ready` = 0 from the edge after B, C held. Release `out_ready` → A, B, C emerge in order, one per cycle, with no duplicates.
- **Flush.** Flush while in TWO with in_valid = 1 → next cycle `out_valid` = 0 and `in_ready` = 1. Neither buffered entry nor the concurrent input is ever output.
- **Illegal encodings.**
  - `0x00000000` → `out_valid` 1, illegal 1, class NONE, all field valids 0.
  - `0x00003003` (ld) → illegal with XLEN=32, legal LOAD with XLEN=64.
  - `0x40001033` (funct7 0x20, funct3 1) → illegal.
- **Reset mid-operation.** Assert `rst` for 1 cycle while in TWO → `out_valid` 0, `in_ready` 1, data outputs 0. The next accepted instruction appears 1 cycle after acceptance.
